// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: fetch FSM state codes, bubble instruction, reset PC.
package cpu_pkg;
  localparam int          INSTR_W          = 32;
  localparam logic [1:0]  S_REQ            = 2'd0;
  localparam logic [1:0]  S_WAIT           = 2'd1;
  localparam logic [1:0]  S_HOLD           = 2'd2;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between stages: bubble beats load beats hold.
// Latency 1 cycle; holds all fields when neither load nor bubble is asserted.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W       = 32,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc4_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc4,
  output logic               vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= BUBBLE_INSTR;
      pc4   <= '0;
      vld   <= 1'b0;
    end else if (bubble) begin
      instr <= BUBBLE_INSTR;
      pc4   <= '0;
      vld   <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc4   <= pc4_in;
      vld   <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, single-outstanding imem handshake, one-word hold buffer, IF/ID register.
// Request to IF/ID is one edge after the response; Stall parks one word in the hold buffer.
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(RESET_PC_DEFAULT),
  parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               Clk,
  input  logic               Rst_n,
  output logic               ImemReqValid,
  input  logic               ImemReqReady,
  output logic [ADDR_W-1:0]  ImemReqAddr,
  input  logic               ImemRspValid,
  input  logic [INSTR_W-1:0] ImemRspData,
  input  logic               RedirectValid,
  input  logic [ADDR_W-1:0]  RedirectPC,
  input  logic               Stall,
  input  logic               Flush,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  PCPlus4,
  output logic               IdValid
);

  logic [1:0]         state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_pc;
  logic               drop;
  logic               hold_vld;
  logic [INSTR_W-1:0] hold_dat;
  logic [ADDR_W-1:0]  hold_pc4;

  logic               deliver;
  logic               id_load;
  logic               id_bubble;
  logic [INSTR_W-1:0] id_instr_in;
  logic [ADDR_W-1:0]  id_pc4_in;
  logic [ADDR_W-1:0]  redirect_aligned;

  assign ImemReqValid     = (state == S_REQ);
  assign ImemReqAddr      = pc;
  assign redirect_aligned = RedirectPC & ~ADDR_W'(3);

  // A response is only live in S_WAIT; stale, redirected or flushed ones go nowhere.
  assign deliver     = (state == S_WAIT) && ImemRspValid && !drop && !RedirectValid && !Flush;
  assign id_bubble   = Flush || (!Stall && !hold_vld && !deliver);
  assign id_load     = !Stall && (hold_vld || deliver);
  assign id_instr_in = hold_vld ? hold_dat : ImemRspData;
  assign id_pc4_in   = hold_vld ? hold_pc4 : req_pc + ADDR_W'(4);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      drop     <= 1'b0;
      hold_vld <= 1'b0;
      hold_dat <= '0;
      hold_pc4 <= '0;
    end else if (RedirectValid) begin
      pc       <= redirect_aligned;
      hold_vld <= 1'b0;
      // An in-flight request must still be drained, so wait for it marked as dropped.
      case (state)
        S_REQ: begin
          if (ImemReqReady) begin
            state <= S_WAIT;
            drop  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (ImemRspValid) begin
            state <= S_REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (ImemReqReady) begin
            pc     <= pc + ADDR_W'(4);
            req_pc <= pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ImemRspValid) begin
            drop <= 1'b0;
            if (deliver && Stall) begin
              hold_vld <= 1'b1;
              hold_dat <= ImemRspData;
              hold_pc4 <= req_pc + ADDR_W'(4);
              state    <= S_HOLD;
            end else begin
              state    <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!Stall || Flush) begin
            hold_vld <= 1'b0;
            state    <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W       (ADDR_W),
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .load     (id_load),
    .bubble   (id_bubble),
    .instr_in (id_instr_in),
    .pc4_in   (id_pc4_in),
    .instr    (Instruction),
    .pc4      (PCPlus4),
    .vld      (IdValid)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed fetch scenarios followed by random stall/ready/latency/redirect traffic,
// scored against an in-order program-stream model and a simple latency memory.
module tb_instr_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [31:0] ImemReqAddr;
  logic        ImemRspValid;
  logic [31:0] ImemRspData;
  logic        RedirectValid;
  logic [31:0] RedirectPC;
  logic        Stall;
  logic        Flush;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic        IdValid;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned consumed = 0;

  logic [31:0] exp_pc4;
  logic        pend;
  int          cnt;
  int          lat;
  logic [31:0] paddr;

  instr_fetch_stage dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .ImemReqValid  (ImemReqValid),
    .ImemReqReady  (ImemReqReady),
    .ImemReqAddr   (ImemReqAddr),
    .ImemRspValid  (ImemRspValid),
    .ImemRspData   (ImemRspData),
    .RedirectValid (RedirectValid),
    .RedirectPC    (RedirectPC),
    .Stall         (Stall),
    .Flush         (Flush),
    .Instruction   (Instruction),
    .PCPlus4       (PCPlus4),
    .IdValid       (IdValid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // One clock: snapshot pre-edge, advance, score the program stream, then step the memory.
  task automatic tick();
    logic        acc, pre_idv, pre_stall, pre_flush, pre_redir, pre_reqv, pre_rdy;
    logic [31:0] pre_pc4, pre_addr, pre_rpc;
    acc       = ImemReqValid && ImemReqReady;
    pre_idv   = IdValid;
    pre_stall = Stall;
    pre_flush = Flush;
    pre_redir = RedirectValid;
    pre_reqv  = ImemReqValid;
    pre_rdy   = ImemReqReady;
    pre_pc4   = PCPlus4;
    pre_addr  = ImemReqAddr;
    pre_rpc   = RedirectPC;
    @(posedge Clk);
    #1;
    if (pre_idv && !pre_stall && !pre_flush) begin
      chk("consume_pc4", pre_pc4, exp_pc4);
      exp_pc4 = exp_pc4 + 32'd4;
      consumed++;
    end
    if (pre_redir) exp_pc4 = (pre_rpc & ~32'h3) + 32'd4;
    if (IdValid) chk("id_word", Instruction, mem_word(PCPlus4 - 32'd4));
    if (pre_reqv && !pre_rdy && !pre_redir) begin
      chk("req_hold_vld", {31'd0, ImemReqValid}, 32'd1);
      chk("req_hold_addr", ImemReqAddr, pre_addr);
    end
    ImemRspValid = 1'b0;
    ImemRspData  = $urandom;
    if (acc) begin
      chk("one_outstanding", {31'd0, pend}, 32'd0);
      pend  = 1'b1;
      cnt   = lat;
      paddr = pre_addr;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend         = 1'b0;
        ImemRspValid = 1'b1;
        ImemRspData  = mem_word(paddr);
      end
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    ImemReqReady = 1'b1;
    ImemRspValid = 1'b0;
    ImemRspData = 32'h0;
    RedirectValid = 1'b0;
    RedirectPC = 32'h0;
    Stall = 1'b0;
    Flush = 1'b0;
    exp_pc4 = 32'd4;
    pend = 1'b0;
    cnt = 0;
    lat = 1;
    paddr = 32'h0;

    #1;
    chk("rst_req_vld", {31'd0, ImemReqValid}, 32'd1);
    chk("rst_req_addr", ImemReqAddr, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_pc4", PCPlus4, 32'h0);
    chk("rst_idvalid", {31'd0, IdValid}, 32'd0);

    // 1: first word two edges after release
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    tick();
    chk("t1_instr", Instruction, 32'h2008_0005);
    chk("t1_pc4", PCPlus4, 32'd4);
    chk("t1_idvalid", {31'd0, IdValid}, 32'd1);

    // 2: stall while the PC=8 response arrives
    tick();
    tick();
    chk("t2_pre_pc4", PCPlus4, 32'd8);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_frozen_pc4", PCPlus4, 32'd8);
      chk("t2_frozen_instr", Instruction, mem_word(32'd4));
      chk("t2_frozen_vld", {31'd0, IdValid}, 32'd1);
      chk("t2_no_req", {31'd0, ImemReqValid}, 32'd0);
    end
    Stall = 1'b0;
    tick();
    chk("t2_buf_pc4", PCPlus4, 32'd12);
    chk("t2_buf_instr", Instruction, mem_word(32'd8));
    chk("t2_next_addr", ImemReqAddr, 32'd12);

    // 3: redirect + flush while waiting on a response
    tick();
    chk("t3_in_wait", {31'd0, ImemReqValid}, 32'd0);
    RedirectValid = 1'b1;
    Flush = 1'b1;
    RedirectPC = 32'h40;
    tick();
    RedirectValid = 1'b0;
    Flush = 1'b0;
    chk("t3_bubble", {31'd0, IdValid}, 32'd0);
    chk("t3_req_addr", ImemReqAddr, 32'h40);
    chk("t3_req_vld", {31'd0, ImemReqValid}, 32'd1);
    tick();
    tick();
    chk("t3_target_pc4", PCPlus4, 32'h44);
    chk("t3_target_vld", {31'd0, IdValid}, 32'd1);

    // 4: memory refuses for five cycles
    ImemReqReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_vld", {31'd0, ImemReqValid}, 32'd1);
      chk("t4_addr", ImemReqAddr, 32'h44);
    end

    // 6: wrap of the fetch address past the top of memory
    RedirectValid = 1'b1;
    Flush = 1'b1;
    RedirectPC = 32'hFFFF_FFFE;
    tick();
    RedirectValid = 1'b0;
    Flush = 1'b0;
    chk("t6_addr_top", ImemReqAddr, 32'hFFFF_FFFC);
    ImemReqReady = 1'b1;
    tick();
    chk("t6_addr_wrap", ImemReqAddr, 32'h0);
    tick();
    chk("t6_pc4_wrap", PCPlus4, 32'h0);
    chk("t6_instr", Instruction, mem_word(32'hFFFF_FFFC));
    chk("t6_vld", {31'd0, IdValid}, 32'd1);

    // 5: async reset mid-wait, then a stray response
    lat = 3;
    tick();
    chk("t5_in_wait", {31'd0, ImemReqValid}, 32'd0);
    #2 Rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", {31'd0, ImemReqValid}, 32'd1);
    chk("t5_rst_addr", ImemReqAddr, 32'h0);
    chk("t5_rst_instr", Instruction, 32'h0);
    chk("t5_rst_pc4", PCPlus4, 32'h0);
    chk("t5_rst_idvalid", {31'd0, IdValid}, 32'd0);
    #2 Rst_n = 1'b1;
    pend = 1'b0;
    exp_pc4 = 32'd4;
    ImemReqReady = 1'b0;
    ImemRspValid = 1'b1;
    ImemRspData = 32'hDEAD_BEEF;
    @(posedge Clk);
    #1;
    ImemRspValid = 1'b0;
    chk("t5_stray_vld", {31'd0, IdValid}, 32'd0);
    chk("t5_stray_instr", Instruction, 32'h0);
    chk("t5_stray_addr", ImemReqAddr, 32'h0);
    ImemReqReady = 1'b1;

    // Random traffic against the stream model
    for (int i = 0; i < 3000; i++) begin
      Stall        = ($urandom_range(0, 9) < 3);
      ImemReqReady = ($urandom_range(0, 9) < 7);
      lat          = $urandom_range(1, 3);
      if ($urandom_range(0, 49) == 0) begin
        RedirectValid = 1'b1;
        Flush         = 1'b1;
        RedirectPC    = $urandom;
      end else begin
        RedirectValid = 1'b0;
        Flush         = 1'b0;
      end
      tick();
    end
    chk("progress", {31'd0, consumed > 200}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
